bnn_conv_engine: RTL and testbench

// - Multi-output-channel binary 3x3-class convolution engine; next generation of the single-OC conv core.
// - Generalised kernel size, stride and output-channel count; start/busy/done handshake; per-OC threshold; abort.
// - Sits between binary feature-map registers and the next BNN layer.
// - Computes one channel's KxK XNOR-popcount per cycle.

---
 rtl/bnn_conv_engine.sv | 176 +++++++++++++++++
 tb/tb_bnn_conv_engine.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_conv_engine.sv
// bnn_conv_engine: multi-OC binary KxK XNOR-popcount conv, one input channel per cycle.
// Define BNN_CONV_PAD_EN for zero-padded "same"-size output.
module bnn_conv_engine #(
  parameter int IC = 8,
  parameter int OC = 4,
  parameter int IMG_IN_SIZE = 30,
  parameter int K = 3,
  parameter int STRIDE = 1,
`ifdef BNN_CONV_PAD_EN
  localparam int PAD = (K - 1) / 2,
`else
  localparam int PAD = 0,
`endif
  localparam int IMG_OUT_SIZE = (IMG_IN_SIZE + 2 * PAD - K) / STRIDE + 1,
  localparam int PW = $clog2(IC * K * K + 1) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic [IC-1:0][IMG_IN_SIZE*IMG_IN_SIZE-1:0] img_in,
  input  logic [OC*IC*K*K-1:0] weights,
  input  logic [OC*PW-1:0] thresh,
  output logic [OC-1:0][IMG_OUT_SIZE*IMG_OUT_SIZE-1:0] img_out,
  output logic busy,
  output logic done
);

  localparam int N   = IMG_OUT_SIZE;
  localparam int NI  = IMG_IN_SIZE;
  localparam int KK  = K * K;
  localparam int ICW = (IC > 1) ? $clog2(IC) : 1;
  localparam int OCW = (OC > 1) ? $clog2(OC) : 1;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int IXW = (NI * NI > 1) ? $clog2(NI * NI) : 1;
  localparam int PXW = (N * N > 1) ? $clog2(N * N) : 1;

  typedef enum logic [1:0] {IDLE, ACC, WR, DONE} state_t;

  state_t state, state_nx;

  logic [OCW-1:0] oc;
  logic [CW-1:0] row, col;
  logic [ICW-1:0] ic;
  logic signed [PW-1:0] acc, tap_sum, thr;
  logic [NI*NI-1:0] map;
  logic [KK-1:0] wk;
  logic last_ic, last_pix, ge;
  logic [PXW-1:0] pix;

  assign last_ic  = (ic == ICW'(IC - 1));
  assign last_pix = (col == CW'(N - 1)) && (row == CW'(N - 1))
                 && (oc == OCW'(OC - 1));
  assign pix = PXW'(int'(row) * N + int'(col));
  assign ge  = (acc >= thr);

  always_comb begin : sel
    map = img_in[0];
    wk  = weights[KK-1:0];
    thr = thresh[PW-1:0];
    for (int i = 0; i < IC; i++)
      if (ic == ICW'(i)) map = img_in[i];
    for (int o = 0; o < OC; o++) begin
      if (oc == OCW'(o)) thr = thresh[o*PW +: PW];
      for (int i = 0; i < IC; i++)
        if (oc == OCW'(o) && ic == ICW'(i))
          wk = weights[(o*IC+i)*KK +: KK];
    end
  end

  // XNOR-popcount of one channel window, +1 per match, -1 per mismatch
  always_comb begin : taps
    int r, c, s;
    logic px;
    r = 0;
    c = 0;
    s = 0;
    px = 1'b0;
    for (int kr = 0; kr < K; kr++) begin
      for (int kc = 0; kc < K; kc++) begin
        r = int'(row) * STRIDE + kr - PAD;
        c = int'(col) * STRIDE + kc - PAD;
`ifdef BNN_CONV_PAD_EN
        if (r >= 0 && r < NI && c >= 0 && c < NI)
          px = map[IXW'(r * NI + c)];
        else
          px = 1'b0;
`else
        px = map[IXW'(r * NI + c)];
`endif
        s = s + ((px == wk[kr*K+kc]) ? 1 : -1);
      end
    end
    tap_sum = PW'(s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = ACC;
      ACC:  if (last_ic) state_nx = WR;
      WR:   state_nx = last_pix ? DONE : ACC;
      DONE: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      oc      <= '0;
      row     <= '0;
      col     <= '0;
      ic      <= '0;
      acc     <= '0;
    end else if (abort) begin
      busy <= 1'b0;
      done <= 1'b0;
      oc   <= '0;
      row  <= '0;
      col  <= '0;
      ic   <= '0;
      acc  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            img_out <= '0;
            oc      <= '0;
            row     <= '0;
            col     <= '0;
            ic      <= '0;
            acc     <= '0;
          end
        end
        ACC: begin
          acc <= acc + tap_sum;
          if (!last_ic) ic <= ic + 1'b1;
        end
        WR: begin
          for (int o = 0; o < OC; o++)
            if (oc == OCW'(o)) img_out[o][pix] <= ge;
          acc <= '0;
          ic  <= '0;
          if (col == CW'(N - 1)) begin
            col <= '0;
            if (row == CW'(N - 1)) begin
              row <= '0;
              if (oc == OCW'(OC - 1)) oc <= '0;
              else                    oc <= oc + 1'b1;
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            col <= col + 1'b1;
          end
          if (last_pix) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_conv_engine.sv
// tb_bnn_conv_engine: directed vector table plus handshake, abort and reset sequences.
// Three engine instances cover small, large multi-OC and strided shapes.
module tb_bnn_conv_engine;

`ifdef BNN_CONV_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif
  localparam int N0 = (4 + 2 * PAD - 3) + 1;
  localparam int P0 = N0 * N0;
  localparam int N1 = (30 + 2 * PAD - 3) + 1;
  localparam int N2 = (7 + 2 * PAD - 3) / 2 + 1;
  localparam int LAT0 = P0 * 2 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, abort, start0, start1, start2;

  logic [0:0][15:0] img0;
  logic [8:0] w0;
  logic [4:0] th0;
  logic [0:0][P0-1:0] out0;
  logic busy0, done0;

  logic [7:0][899:0] img1;
  logic [143:0] w1;
  logic [15:0] th1;
  logic [1:0][N1*N1-1:0] out1;
  logic busy1, done1;

  logic [0:0][48:0] img2;
  logic [8:0] w2;
  logic [4:0] th2;
  logic [0:0][N2*N2-1:0] out2;
  logic busy2, done2;

  bnn_conv_engine #(.IC(1), .OC(1), .IMG_IN_SIZE(4), .K(3), .STRIDE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort),
    .img_in(img0), .weights(w0), .thresh(th0),
    .img_out(out0), .busy(busy0), .done(done0));

  bnn_conv_engine #(.IC(8), .OC(2), .IMG_IN_SIZE(30), .K(3), .STRIDE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
    .img_in(img1), .weights(w1), .thresh(th1),
    .img_out(out1), .busy(busy1), .done(done1));

  bnn_conv_engine #(.IC(1), .OC(1), .IMG_IN_SIZE(7), .K(3), .STRIDE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort),
    .img_in(img2), .weights(w2), .thresh(th2),
    .img_out(out2), .busy(busy2), .done(done2));

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [2047:0] act,
                     input logic [2047:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic dsel(input int w);
    return (w == 0) ? done0 : (w == 1) ? done1 : done2;
  endfunction

  function automatic logic bsel(input int w);
    return (w == 0) ? busy0 : (w == 1) ? busy1 : busy2;
  endfunction

  // Start a frame; dc = cycle where done is seen, bc = cycles with busy high
  task automatic run(input int w, output int dc, output int bc);
    int cyc;
    if (w == 0) start0 = 1'b1;
    else if (w == 1) start1 = 1'b1;
    else start2 = 1'b1;
    step;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    cyc = 1;
    bc = 0;
    while (!dsel(w) && cyc < 20000) begin
      if (bsel(w)) bc++;
      step;
      cyc++;
    end
    dc = cyc;
  endtask

  typedef struct {
    string nm;
    logic [15:0] img;
    logic [8:0] w;
    logic [4:0] th;
    logic [P0-1:0] ex;
  } vec_t;

  initial begin
    vec_t v[$];
    int dc, bc, np, cyc;

    rst_n = 1'b0;
    abort = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    img0 = '0;
    w0 = '0;
    th0 = '0;
    img1 = '0;
    w1 = '0;
    th1 = '0;
    img2 = '0;
    w2 = '0;
    th2 = '0;
    step;
    step;
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_out", out0, '0);
    rst_n = 1'b1;
    step;

`ifdef BNN_CONV_PAD_EN
    v.push_back('{"pad_zero", 16'h0000, 9'h000, 5'd0, 16'hFFFF});
    v.push_back('{"pad_ones", 16'hFFFF, 9'h1FF, 5'd0, 16'h6FF6});
`else
    v.push_back('{"all1_w1", 16'hFFFF, 9'h1FF, 5'd0, 4'b1111});
    v.push_back('{"all1_w0", 16'hFFFF, 9'h000, 5'd0, 4'b0000});
    v.push_back('{"thr_m9", 16'hFFFF, 9'h000, 5'b10111, 4'b1111});
    v.push_back('{"thr_m8", 16'hFFFF, 9'h000, 5'b11000, 4'b0000});
    v.push_back('{"img0_w1", 16'h0000, 9'h1FF, 5'd0, 4'b0000});
    v.push_back('{"px00", 16'h0001, 9'h000, 5'd8, 4'b1110});
    v.push_back('{"px33", 16'h8000, 9'h000, 5'd8, 4'b0111});
    v.push_back('{"px02", 16'h0004, 9'h000, 5'd8, 4'b1100});
    v.push_back('{"px00_w00", 16'h0001, 9'h001, 5'd8, 4'b0001});
`endif

    for (int i = 0; i < v.size(); i++) begin
      img0[0] = v[i].img;
      w0 = v[i].w;
      th0 = v[i].th;
      run(0, dc, bc);
      chk({v[i].nm, "_out"}, out0, v[i].ex);
      chk({v[i].nm, "_lat"}, dc, LAT0);
      if (i == 0) begin
        chk("busy_cycles0", bc, LAT0 - 1);
        chk("busy_at_done", busy0, 1'b0);
      end
      step;
      if (i == 0) chk("done_pulse_1cyc", done0, 1'b0);
    end

    // start held high for the whole frame
    img0[0] = 16'hFFFF;
    w0 = 9'h1FF;
    th0 = '0;
    start0 = 1'b1;
    step;
    cyc = 1;
    while (!done0 && cyc < 200) begin
      step;
      cyc++;
    end
    chk("hold_lat", cyc, LAT0);
    start0 = 1'b0;
    np = 0;
    for (int j = 0; j < 20; j++) begin
      step;
      if (done0 || busy0) np++;
    end
    chk("hold_no_restart", np, 0);

`ifndef BNN_CONV_PAD_EN
    // strided checkerboard, matching weights at every even origin
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        img2[0][r*7+c] = ((r + c) % 2) == 1;
    for (int t = 0; t < 9; t++)
      w2[t] = (((t / 3) + (t % 3)) % 2) == 1;
    th2 = 5'd9;
    run(2, dc, bc);
    chk("stride_out", out2, 9'h1FF);
    chk("stride_lat", dc, 9 * 2 + 1);
    step;

    // two OCs, eight ICs: oc0 matches the maps, oc1 is inverted
    for (int i = 0; i < 8; i++) begin
      img1[i] = (i % 2 == 0) ? '1 : '0;
      for (int o = 0; o < 2; o++)
        for (int t = 0; t < 9; t++)
          w1[(o*8+i)*9+t] = (i % 2 == 0) ^ (o == 1);
    end
    th1 = '0;
    start1 = 1'b1;
    step;
    start1 = 1'b0;
    for (cyc = 1; cyc < 50; cyc++) step;
    abort = 1'b1;
    step;
    abort = 1'b0;
    chk("abort_busy", busy1, 1'b0);
    chk("abort_done", done1, 1'b0);
    chk("abort_partial", out1[0][5:0], 6'b011111);
    start1 = 1'b1;
    step;
    start1 = 1'b0;
    chk("restart_clear", out1, '0);
    chk("restart_busy", busy1, 1'b1);
    cyc = 1;
    bc = 0;
    while (!done1 && cyc < 20000) begin
      if (busy1) bc++;
      step;
      cyc++;
    end
    chk("big_busy_cycles", bc, 2 * 784 * 9);
    chk("big_lat", cyc, 2 * 784 * 9 + 1);
    chk("big_oc0", out1[0], {784{1'b1}});
    chk("big_oc1", out1[1], '0);
    step;
`endif

    // asynchronous reset in the middle of a frame
    img0[0] = 16'hFFFF;
    w0 = 9'h1FF;
    th0 = '0;
    start0 = 1'b1;
    step;
    start0 = 1'b0;
    for (int j = 0; j < 5; j++) step;
    chk("mid_partial", out0[0][0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy0, 1'b0);
    chk("midrst_out", out0, '0);
    #2;
    rst_n = 1'b1;
    np = 0;
    for (int j = 0; j < 40; j++) begin
      step;
      if (done0) np++;
    end
    chk("midrst_no_done", np, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
